mem_data_lsu: RTL and testbench

Parametrised data memory with a built-in load/store formatter for the TRV core's memory stage. It accepts one request at a time over a valid/ready handshake, decodes RISC-V `funct3` size and sign, and generates byte enables. It returns sign- or zero-extended load data, or a store acknowledge, on a single-cycle response strobe. Errors are flagged for illegal size, out-of-range address and, when split support is compiled out, misalignment.

---
 rtl/mem_data_lsu.sv | 127 ++++++++++++
 tb/tb_mem_data_lsu.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_data_lsu.sv
// mem_data_lsu: data memory with RISC-V load/store size/sign formatting for the memory stage.
// Define MEM_DATA_LSU_MISALIGN_EN to split word-crossing misaligned accesses instead of faulting them.
module mem_data_lsu #(
  parameter int B_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [B_WIDTH-1:0]    req_wdata,
  output logic                  rsp_valid,
  output logic [B_WIDTH-1:0]    rsp_rdata,
  output logic                  rsp_err
);
  localparam int NB = B_WIDTH / 8;
  localparam int OW = $clog2(NB);
  localparam int DW = MEM_DEPTH_LOG2;
  localparam logic [B_WIDTH-1:0] ONE = B_WIDTH'(1);
`ifdef MEM_DATA_LSU_MISALIGN_EN
  localparam int WN = 2;
  typedef enum logic [1:0] {IDLE, SPLIT, RESP} state_t;
`else
  localparam int WN = 1;
  typedef enum logic [1:0] {IDLE, RESP} state_t;
`endif

  logic [B_WIDTH-1:0] mem [2**DW];
  state_t state, state_nx;
  logic accept, legal, in_range, err;
  logic [3:0] size, sz_q;
  logic [OW-1:0] off, off_q;
  logic [DW-1:0] idx;
  logic [WN*NB-1:0] be;
  logic [WN*B_WIDTH-1:0] wd, win;
  logic we_q, err_q, sgn;
  logic [2:0] f3_q;
  logic [B_WIDTH-1:0] rd_lo, raw, mask, fmt;

  assign accept = req_valid && state == IDLE;
  assign size = 4'd1 << req_funct3[1:0];
  assign off = req_addr[OW-1:0];
  assign idx = req_addr[OW +: DW];
  assign in_range = (req_addr >> (OW + DW)) == '0;
  assign legal = (req_funct3[1:0] == 2'b11) ? (!req_funct3[2] && B_WIDTH == 64)
               : req_funct3[2] ? (!req_we && (req_funct3[1:0] != 2'b10 || B_WIDTH == 64)) : 1'b1;
  // Byte enables and store data laid out over a window of WN consecutive words.
  assign be = (WN*NB)'((16'd1 << size) - 16'd1) << off;
  assign wd = (WN*B_WIDTH)'(req_wdata) << {off, 3'b000};

`ifdef MEM_DATA_LSU_MISALIGN_EN
  logic span;
  logic [DW-1:0] idx_q;
  logic [NB-1:0] be_hi;
  logic [B_WIDTH-1:0] wd_hi, rd_hi;
  assign span = (5'(off) + 5'(size)) > 5'(NB);
  assign err = !legal || !in_range || (span && idx == '1);
  assign win = {rd_hi, rd_lo};
`else
  logic mis;
  assign mis = |(4'(off) & (size - 4'd1));
  assign err = !legal || !in_range || mis;
  assign win = rd_lo;
`endif

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else state <= state_nx;
  end

  always_comb begin
    state_nx = IDLE;
    case (state)
`ifdef MEM_DATA_LSU_MISALIGN_EN
      IDLE: state_nx = !req_valid ? IDLE : (span && !err) ? SPLIT : RESP;
      SPLIT: state_nx = RESP;
`else
      IDLE: state_nx = req_valid ? RESP : IDLE;
`endif
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst && accept) begin
      we_q <= req_we;
      f3_q <= req_funct3;
      off_q <= off;
      err_q <= err;
      rd_lo <= mem[idx];
      if (req_we && !err)
        for (int b = 0; b < NB; b++)
          if (be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
`ifdef MEM_DATA_LSU_MISALIGN_EN
      idx_q <= idx;
      be_hi <= be[2*NB-1:NB];
      wd_hi <= wd[2*B_WIDTH-1:B_WIDTH];
`endif
    end
`ifdef MEM_DATA_LSU_MISALIGN_EN
    if (rst && state == SPLIT) begin
      rd_hi <= mem[idx_q + DW'(1)];
      if (we_q)
        for (int b = 0; b < NB; b++)
          if (be_hi[b]) mem[idx_q + DW'(1)][8*b +: 8] <= wd_hi[8*b +: 8];
    end
`endif
  end

  // Aligned accesses never reach past the low word after the shift, so stale rd_hi is masked off.
  always_comb begin
    sz_q = 4'd1 << f3_q[1:0];
    raw = B_WIDTH'(win >> {off_q, 3'b000});
    mask = (ONE << {sz_q, 3'b000}) - ONE;
    sgn = !f3_q[2] && |(raw & mask & ~(mask >> 1));
    fmt = (raw & mask) | (sgn ? ~mask : '0);
  end

  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  assign rsp_err = rsp_valid && err_q;
  assign rsp_rdata = (rsp_valid && !err_q && !we_q) ? fmt : '0;
endmodule

// File: tb/tb_mem_data_lsu.sv
// tb_mem_data_lsu: directed vector table, handshake/reset sequences and randomized requests
// checked against a byte-array reference model; honours MEM_DATA_LSU_MISALIGN_EN.
module tb_mem_data_lsu;
  logic clk = 1'b0, rst = 1'b0, req_valid = 1'b0, req_we = 1'b0;
  logic [2:0] req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  int checks = 0, failures = 0;
  logic [7:0] mm [4096];

  typedef struct {
    logic we;
    logic [2:0] f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic er;
    int lat;
  } vec_t;
  vec_t tab[$];

  always #5 clk = ~clk;

  mem_data_lsu dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  // Reference: byte-addressed memory, access rules straight from funct3 size/sign semantics.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output logic [31:0] rd, output logic er,
                                output int lat);
    int sz = 1 << f3[1:0];
    longint v = 0;
    rd = 32'd0;
    lat = 1;
    er = !(f3 <= 3'd2 || (!we && (f3 == 3'd4 || f3 == 3'd5))) || a >= 32'd4096;
`ifdef MEM_DATA_LSU_MISALIGN_EN
    if (!er && (a % 4) + sz > 4) begin
      if (a + sz > 4096) er = 1'b1;
      else lat = 2;
    end
`else
    if (!er && a % sz != 0) er = 1'b1;
`endif
    if (er) return;
    for (int i = 0; i < sz; i++)
      if (we) mm[a + i] = wd[8*i +: 8];
      else v = v | (longint'(mm[a + i]) << (8 * i));
    if (!we && !f3[2] && v[8*sz-1]) v = v - (longint'(1) << (8 * sz));
    rd = we ? 32'd0 : v[31:0];
  endfunction

  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int lat);
    for (int n = 0; n < 8 && !req_ready; n++) begin
      @(posedge clk); #1;
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    rd = 'x; er = 1'bx; lat = 0;
    for (int n = 1; n <= 4; n++) begin
      if (rsp_valid) begin
        lat = n; rd = rsp_rdata; er = rsp_err;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    chk("rsp_one_cycle", 32'(rsp_valid), 32'd0);
  endtask

  task automatic check_req(input string nm, input logic we, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] rd, mrd;
    logic er, mer;
    int lat, mlat;
    model(we, f3, a, wd, mrd, mer, mlat);
    xact(we, f3, a, wd, rd, er, lat);
    chk({nm, "_rdata"}, rd, mrd);
    chk({nm, "_err"}, 32'(er), 32'(mer));
    chk({nm, "_lat"}, lat, mlat);
  endtask

  initial begin
    logic [31:0] rd, mrd;
    logic er, mer;
    int lat, mlat, pulses;

    tab.push_back('{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1});
    tab.push_back('{1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, 1});
    tab.push_back('{1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 1'b0, 1});
    tab.push_back('{1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0, 1});
    tab.push_back('{1'b0, 3'b101, 32'h12, 32'h0, 32'h0000DEAD, 1'b0, 1});
    tab.push_back('{1'b1, 3'b000, 32'h11, 32'h12345655, 32'h0, 1'b0, 1});
    tab.push_back('{1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0, 1});
    tab.push_back('{1'b1, 3'b010, 32'h10, 32'h44332211, 32'h0, 1'b0, 1});
    tab.push_back('{1'b1, 3'b010, 32'h14, 32'h88776655, 32'h0, 1'b0, 1});
`ifdef MEM_DATA_LSU_MISALIGN_EN
    tab.push_back('{1'b0, 3'b010, 32'h12, 32'h0, 32'h66554433, 1'b0, 2});
`else
    tab.push_back('{1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1, 1});
    tab.push_back('{1'b0, 3'b001, 32'h11, 32'h0, 32'h0, 1'b1, 1});
`endif
    tab.push_back('{1'b1, 3'b010, 32'h1000, 32'h12345678, 32'h0, 1'b1, 1});
    tab.push_back('{1'b0, 3'b010, 32'h0, 32'h0, 32'h0, 1'b0, 1});
    tab.push_back('{1'b0, 3'b111, 32'h10, 32'h0, 32'h0, 1'b1, 1});
    tab.push_back('{1'b1, 3'b001, 32'h16, 32'h0000ABCD, 32'h0, 1'b0, 1});
    tab.push_back('{1'b0, 3'b010, 32'h14, 32'h0, 32'hABCD6655, 1'b0, 1});
    tab.push_back('{1'b1, 3'b100, 32'h18, 32'h0, 32'h0, 1'b1, 1});
    tab.push_back('{1'b0, 3'b011, 32'h18, 32'h0, 32'h0, 1'b1, 1});
    tab.push_back('{1'b0, 3'b010, 32'hFFE, 32'h0, 32'h0, 1'b1, 1});
    tab.push_back('{1'b1, 3'b001, 32'hFFE, 32'h0000BEEF, 32'h0, 1'b0, 1});
    tab.push_back('{1'b0, 3'b010, 32'hFFC, 32'h0, 32'hBEEF0000, 1'b0, 1});

    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    rst = 1'b1;

    for (int w = 0; w < 16; w++) check_req("init_lo", 1'b1, 3'b010, 32'(4 * w), 32'd0);
    for (int w = 1020; w < 1024; w++) check_req("init_hi", 1'b1, 3'b010, 32'(4 * w), 32'd0);

    foreach (tab[i]) begin
      model(tab[i].we, tab[i].f3, tab[i].a, tab[i].wd, mrd, mer, mlat);
      xact(tab[i].we, tab[i].f3, tab[i].a, tab[i].wd, rd, er, lat);
      chk($sformatf("vec%0d_rdata", i), rd, tab[i].rd);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(tab[i].er));
      chk($sformatf("vec%0d_lat", i), lat, tab[i].lat);
    end

    // Back-to-back requests with req_valid held high; inputs change right after the first accept.
    model(1'b1, 3'b010, 32'h20, 32'h11112222, mrd, mer, mlat);
    model(1'b0, 3'b010, 32'h20, 32'h0, mrd, mer, mlat);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h11112222;
    @(posedge clk); #1;
    chk("busy_ready_in_resp", 32'(req_ready), 32'd0);
    chk("busy_a_valid", 32'(rsp_valid), 32'd1);
    chk("busy_a_err", 32'(rsp_err), 32'd0);
    pulses = int'(rsp_valid);
    req_we = 1'b0; req_wdata = 32'd0;
    @(posedge clk); #1;
    chk("busy_gap_valid", 32'(rsp_valid), 32'd0);
    chk("busy_ready_idle", 32'(req_ready), 32'd1);
    pulses += int'(rsp_valid);
    @(posedge clk); #1;
    chk("busy_b_valid", 32'(rsp_valid), 32'd1);
    chk("busy_b_rdata", rsp_rdata, 32'h11112222);
    pulses += int'(rsp_valid);
    req_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      pulses += int'(rsp_valid);
    end
    chk("busy_pulses", pulses, 2);

    // Reset landing on the response cycle clears the response outputs.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("rst_resp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_resp_err", 32'(rsp_err), 32'd0);
    chk("rst_resp_rdata", rsp_rdata, 32'd0);
    chk("rst_resp_ready", 32'(req_ready), 32'd1);

`ifdef MEM_DATA_LSU_MISALIGN_EN
    check_req("clr10", 1'b1, 3'b010, 32'h10, 32'd0);
    check_req("clr14", 1'b1, 3'b010, 32'h14, 32'd0);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h12; req_wdata = 32'hAABBCCDD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("split_first_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("split_rst_ready", 32'(req_ready), 32'd1);
    pulses = int'(rsp_valid);
    repeat (3) begin
      @(posedge clk); #1;
      pulses += int'(rsp_valid);
    end
    chk("split_rst_no_valid", pulses, 0);
    mm[12'h12] = 8'hDD;
    mm[12'h13] = 8'hCC;
    xact(1'b0, 3'b010, 32'h10, 32'd0, rd, er, lat);
    chk("split_lo_word", rd, 32'hCCDD0000);
    xact(1'b0, 3'b010, 32'h14, 32'd0, rd, er, lat);
    chk("split_hi_word", rd, 32'h00000000);
`endif

    for (int k = 0; k < 150; k++) begin
      logic [31:0] a;
      int s;
      s = $urandom_range(0, 9);
      a = (s == 0) ? 32'hFF0 + 32'($urandom_range(0, 15))
        : (s == 1) ? ($urandom | 32'h1000) : 32'($urandom_range(0, 32'h37));
      check_req($sformatf("rnd%0d", k), 1'($urandom), 3'($urandom), a, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
